axil2apb_bridge: RTL and testbench

AXIL2APB_BRIDGE -- requirements
Module: axil2apb_bridge

---
 rtl/axil2apb_pkg.sv | 14 +
 rtl/axil2apb_bridge.sv | 165 ++++++++++++++++
 tb/tb_axil2apb_bridge.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/axil2apb_pkg.sv
// axil2apb_pkg: shared FSM state encoding and AXI response codes for the AXI4-Lite to APB bridge.
package axil2apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil2apb_bridge.sv
// axil2apb_bridge: AXI4-Lite slave to APB master bridge, one transfer in flight, round-robin read/write arbitration.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module axil2apb_bridge
    import axil2apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_awvalid,
    output logic        in_awready,
    input  logic [31:0] in_awaddr,
    input  logic [2:0]  in_awprot,
    input  logic        in_wvalid,
    output logic        in_wready,
    input  logic [31:0] in_wdata,
    input  logic [3:0]  in_wstrb,
    output logic        in_bvalid,
    input  logic        in_bready,
    output logic [1:0]  in_bresp,
    input  logic        in_arvalid,
    output logic        in_arready,
    input  logic [31:0] in_araddr,
    input  logic [2:0]  in_arprot,
    output logic        in_rvalid,
    input  logic        in_rready,
    output logic [31:0] in_rdata,
    output logic [1:0]  in_rresp,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic [31:0] out_paddr,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic        out_pslverr,
    input  logic [31:0] out_prdata
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic        pref_w_q, pref_w_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  prot_q, prot_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        slverr_q, slverr_d;
    logic        timeout_hit;
    logic        idle, wr_ok, grant_r, grant_w;

    // Readies are gated by reset so nothing handshakes while the bridge is held in reset.
    assign idle    = (state_q == IDLE) & reset;
    assign wr_ok   = in_awvalid & in_wvalid;
    assign grant_r = idle & in_arvalid & (~wr_ok | ~pref_w_q);
    assign grant_w = idle & wr_ok & (~in_arvalid | pref_w_q);

`ifdef APB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d       = (state_q == ACCESS) ? cnt_q + CW'(1) : '0;
        timeout_hit = (state_q == ACCESS) && !out_pready && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        pref_w_d = pref_w_q;
        addr_d   = addr_q;
        prot_d   = prot_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;
        case (state_q)
            IDLE: begin
                if (grant_r) begin
                    state_d  = SETUP;
                    write_d  = 1'b0;
                    pref_w_d = 1'b1;
                    addr_d   = in_araddr;
                    prot_d   = in_arprot;
                    wdata_d  = '0;
                    strb_d   = '0;
                end else if (grant_w) begin
                    state_d  = SETUP;
                    write_d  = 1'b1;
                    pref_w_d = 1'b0;
                    addr_d   = in_awaddr;
                    prot_d   = in_awprot;
                    wdata_d  = in_wdata;
                    strb_d   = in_wstrb;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (out_pready) begin
                    state_d  = RESP;
                    rdata_d  = write_q ? 32'h0 : out_prdata;
                    slverr_d = out_pslverr;
                end else if (timeout_hit) begin
                    state_d  = RESP;
                    rdata_d  = '0;
                    slverr_d = 1'b1;
                end
            end
            RESP: state_d = (write_q ? in_bready : in_rready) ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            pref_w_q <= 1'b0;
            addr_q   <= '0;
            prot_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            pref_w_q <= pref_w_d;
            addr_q   <= addr_d;
            prot_q   <= prot_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
        end
    end

    assign in_awready  = grant_w;
    assign in_wready   = grant_w;
    assign in_arready  = grant_r;
    assign in_bvalid   = (state_q == RESP) & write_q;
    assign in_rvalid   = (state_q == RESP) & ~write_q;
    assign in_bresp    = slverr_q ? RESP_SLVERR : RESP_OKAY;
    assign in_rresp    = slverr_q ? RESP_SLVERR : RESP_OKAY;
    assign in_rdata    = rdata_q;
    assign out_psel    = (state_q == SETUP) | (state_q == ACCESS);
    assign out_penable = (state_q == ACCESS);
    assign out_pprot   = prot_q;
    assign out_paddr   = addr_q;
    assign out_pwrite  = write_q;
    assign out_pwdata  = wdata_q;
    assign out_pstrb   = strb_q;

endmodule

// File: tb/tb_axil2apb_bridge.sv
// tb_axil2apb_bridge: directed self-checking bench for the AXI4-Lite to APB bridge.
module tb_axil2apb_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_awvalid, in_awready, in_wvalid, in_wready, in_bvalid, in_bready;
    logic [31:0] in_awaddr, in_wdata, in_araddr, in_rdata, out_paddr, out_pwdata, out_prdata;
    logic [2:0]  in_awprot, in_arprot, out_pprot;
    logic [3:0]  in_wstrb, out_pstrb;
    logic [1:0]  in_bresp, in_rresp;
    logic        in_arvalid, in_arready, in_rvalid, in_rready;
    logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n, cyc;

    always #5 clock = ~clock;

    axil2apb_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .in_awvalid(in_awvalid), .in_awready(in_awready), .in_awaddr(in_awaddr), .in_awprot(in_awprot),
        .in_wvalid(in_wvalid), .in_wready(in_wready), .in_wdata(in_wdata), .in_wstrb(in_wstrb),
        .in_bvalid(in_bvalid), .in_bready(in_bready), .in_bresp(in_bresp),
        .in_arvalid(in_arvalid), .in_arready(in_arready), .in_araddr(in_araddr), .in_arprot(in_arprot),
        .in_rvalid(in_rvalid), .in_rready(in_rready), .in_rdata(in_rdata), .in_rresp(in_rresp),
        .out_psel(out_psel), .out_penable(out_penable), .out_pprot(out_pprot), .out_paddr(out_paddr),
        .out_pwrite(out_pwrite), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
        .out_pready(out_pready), .out_pslverr(out_pslverr), .out_prdata(out_prdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        in_awvalid = 0; in_awaddr = '0; in_awprot = '0;
        in_wvalid = 0; in_wdata = '0; in_wstrb = '0; in_bready = 0;
        in_arvalid = 0; in_araddr = '0; in_arprot = '0; in_rready = 0;
        out_pready = 0; out_pslverr = 0; out_prdata = '0;
    endtask

    task automatic wait_resp(input logic w, output int c);
        c = 0;
        while (((w ? in_bvalid : in_rvalid) !== 1'b1) && c < 40) begin
            @(negedge clock);
            c++;
        end
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(negedge clock);
        in_arvalid = 1; in_awvalid = 1; in_wvalid = 1; #1;
        chk("rst_ctrl", {in_awready, in_wready, in_arready, in_bvalid, in_rvalid, out_psel, out_penable}, 0);
        chk("rst_resp", {in_bresp, in_rresp}, 0);
        chk("rst_rdata", in_rdata, 0);
        chk("rst_paddr", out_paddr, 0);
        chk("rst_pwdata", out_pwdata, 0);
        chk("rst_pstrb_pprot", {out_pstrb, out_pprot}, 0);
        idle_inputs();
        @(negedge clock) reset = 1;
        @(negedge clock);

        in_awvalid = 1; in_awaddr = 32'h1000_0000; in_awprot = 3'b010; #1;
        chk("aw_only_ready", {in_awready, in_wready, in_arready}, 0);
        @(negedge clock);
        chk("aw_only_psel", out_psel, 0);
        in_wvalid = 1; in_wdata = 32'h0000_00AB; in_wstrb = 4'b0001; out_pready = 1; #1;
        chk("wr_grant", {in_awready, in_wready, in_arready}, 3'b110);
        @(negedge clock);
        in_awvalid = 0; in_wvalid = 0; #1;
        chk("wr_setup", {out_psel, out_penable, out_pwrite, in_awready, in_wready}, 5'b10100);
        chk("wr_paddr", out_paddr, 32'h1000_0000);
        chk("wr_pwdata", out_pwdata, 32'h0000_00AB);
        chk("wr_pstrb", out_pstrb, 4'b0001);
        chk("wr_pprot", out_pprot, 3'b010);
        @(negedge clock);
        chk("wr_access", {out_psel, out_penable, in_bvalid}, 3'b110);
        chk("wr_paddr_hold", out_paddr, 32'h1000_0000);
        @(negedge clock);
        chk("wr_bvalid_3cyc", {in_bvalid, in_bresp, out_psel, out_penable}, 5'b10000);
        in_bready = 1;
        @(negedge clock);
        chk("wr_bdone", in_bvalid, 0);
        idle_inputs();

        in_arvalid = 1; in_araddr = 32'h1000_0005; in_arprot = 3'b001; out_prdata = 32'h4141_4141; #1;
        chk("rd_grant", {in_awready, in_wready, in_arready}, 3'b001);
        @(negedge clock);
        in_arvalid = 0; #1;
        chk("rd_setup", {out_psel, out_penable, out_pwrite}, 3'b100);
        chk("rd_pstrb", out_pstrb, 0);
        chk("rd_pwdata", out_pwdata, 0);
        chk("rd_paddr", out_paddr, 32'h1000_0005);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (out_penable && out_psel) n++;
            if (i == 4) out_pready = 1;
        end
        chk("rd_penable_cycles", n, 5);
        @(negedge clock);
        out_pready = 0;
        chk("rd_rvalid", {in_rvalid, in_rresp, out_psel}, 4'b1000);
        chk("rd_rdata", in_rdata, 32'h4141_4141);
        in_rready = 1;
        @(negedge clock);
        chk("rd_rdone", in_rvalid, 0);
        idle_inputs();

        in_awvalid = 1; in_wvalid = 1; in_awaddr = 32'h2000_0000; in_wdata = 32'h1234_5678; in_wstrb = 4'hF;
        out_pready = 1; out_pslverr = 1; #1;
        chk("err_grant", {in_awready, in_wready}, 2'b11);
        @(negedge clock);
        in_awvalid = 0; in_wvalid = 0;
        repeat (2) @(negedge clock);
        out_pready = 0; out_pslverr = 0;
        for (int i = 0; i < 3; i++) begin
            in_arvalid = 1; in_araddr = 32'h2000_0100; #1;
            chk("err_hold_b", {in_bvalid, in_bresp}, 3'b110);
            chk("err_hold_noapb", {out_psel, out_penable, in_arready}, 0);
            @(negedge clock);
        end
        in_arvalid = 0; in_bready = 1;
        @(negedge clock);
        chk("err_bdone", {in_bvalid, out_psel}, 0);
        idle_inputs();

        in_arvalid = 1; in_araddr = 32'h3000_0000; #1;
        @(negedge clock);
        in_arvalid = 0;
        @(negedge clock);
        chk("abort_in_access", out_penable, 1);
        reset = 0; #1;
        chk("abort_outs", {out_psel, out_penable, in_bvalid, in_rvalid}, 0);
        @(negedge clock) reset = 1;
        @(negedge clock);

        for (int r = 0; r < 4; r++) begin
            in_arvalid = 1; in_awvalid = 1; in_wvalid = 1;
            in_araddr = 32'h4000_0000 + r; in_awaddr = 32'h5000_0000 + r; in_wdata = r; in_wstrb = 4'h3;
            out_pready = 1; out_prdata = 32'hC0DE_0000 + r; in_bready = 1; in_rready = 1; #1;
            chk($sformatf("rr_grant%0d", r), {in_awready, in_wready, in_arready}, r[0] ? 3'b110 : 3'b001);
            @(negedge clock);
            in_arvalid = 0; in_awvalid = 0; in_wvalid = 0;
            chk($sformatf("rr_pwrite%0d", r), out_pwrite, r[0]);
            wait_resp(r[0], cyc);
            chk($sformatf("rr_lat%0d", r), cyc, 2);
            if (r[0]) chk($sformatf("rr_bresp%0d", r), {in_bvalid, in_bresp}, 3'b100);
            else chk($sformatf("rr_rdata%0d", r), in_rdata, 32'hC0DE_0000 + r);
            @(negedge clock);
        end
        idle_inputs();
        @(negedge clock);

`ifdef APB_TIMEOUT_EN
        in_arvalid = 1; in_araddr = 32'h6000_0000; out_prdata = 32'hDEAD_BEEF; #1;
        @(negedge clock);
        in_arvalid = 0;
        n = 0; cyc = 0;
        while (!in_rvalid && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (out_penable) n++;
        end
        chk("to_access_cycles", n, 8);
        chk("to_rvalid", {in_rvalid, in_rresp}, 3'b110);
        chk("to_rdata", in_rdata, 0);
        in_rready = 1;
        @(negedge clock);
        idle_inputs();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
